pe_regfile_rdport: RTL and testbench
====================================

Name: pe_regfile_rdport

Overview:
Parametrised register file for the RISC-V PE. It has a single write port and NUM_RD_PORTS handshaked read ports; it generalises the old combinational 32-way read mux.
- Read requests are accepted with a valid/ready handshake.
- Read data is registered into a one-entry output buffer and held until the consumer takes it.
- It sits between decode (read requests) and writeback (write port), and replaces the separate register bank plus read-mux arrangement.

Parameters:
- NUM_REGS, 32: number of architectural registers (power of two, at least 2).
- DATA_W, 32: register width in bits.
- NUM_RD_PORTS, 2: number of read channels served per request.
- ZERO_REG0, 1: 1 means register 0 reads as zero and ignores writes.
- AW, $clog2(NUM_REGS): address width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.
- req_valid  in  1  read request valid.
- req_ready  out  1  block can accept a request.
- req_addr  in  NUM_RD_PORTS*AW  flattened read addresses; port p is at [p*AW +: AW].
- req_port_en  in  NUM_RD_PORTS  per-port enable mask.
- resp_valid  out  1  response data valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  NUM_RD_PORTS*DATA_W  flattened read data; port p is at [p*DATA_W +: DATA_W].
- resp_port_en  out  NUM_RD_PORTS  mask captured with the request.
- busy  out  1  resp_valid && !resp_ready; this is the successor of regComplete.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - all registers become 0;
  - resp_valid=0, resp_data=0, resp_port_en=0.
  - rst has priority over every concurrent write or request.
- Write:
  - On a clk edge with wr_en=1, mem[wr_addr] <= wr_data.
  - If ZERO_REG0=1 and wr_addr==0, the write is dropped.
- Handshake rules:
  - req_ready = !resp_valid || resp_ready. This is combinational, so back-to-back accepts give full throughput.
  - Accept occurs when req_valid && req_ready at a clk edge.
  - On accept: resp_valid <= 1; resp_port_en <= req_port_en; each enabled port p captures its read value.
  - Ports with req_port_en[p]=0 capture 0, never X.
  - Latency: 1 cycle from accept to resp_valid.
- Response hold:
  - While resp_valid && !resp_ready, resp_data and resp_port_en stay stable.
  - A write to a register that has already been captured does not alter the held data.
- Draining:
  - resp_valid drops to 0 only when resp_ready=1 and there is no accept in the same cycle.
  - Drain and accept in the same cycle: the new data replaces the old and resp_valid stays 1.
- Read value of port p:
  - ZERO_REG0 && addr==0 gives 0.
  - Otherwise, with bypass enabled (see Optional Feature), a same-cycle wr_en && wr_addr==addr gives wr_data.
  - Otherwise the value is mem[addr].
- Simultaneous events:
  - Two ports may read the same address; both receive the same value.
  - Reset in the middle of a held response discards it (resp_valid=0 on the next cycle).
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.
- State machine with two states:
  - EMPTY to FULL on accept.
  - FULL to FULL on accept together with drain.
  - FULL to EMPTY on drain without accept.
  - EMPTY to EMPTY otherwise.

Optional Feature:
- Macro PE_RF_WR_BYPASS_EN.
- Defined: a write in the same cycle as an accept is forwarded into the captured data for any enabled port whose address matches (write-first).
- Undefined: the captured data is the pre-write contents (read-first), and the write becomes visible to requests accepted from the next cycle onward.
- The zero-register rule overrides the bypass in both builds.

Decomposition:
- Package pe_rf_pkg holds:
  - the default constants RF_NUM_REGS=32, RF_DATA_W=32, RF_NUM_RD_PORTS=2;
  - the typedef rf_state_e {RF_EMPTY, RF_FULL}.
- One sub-module, pe_rf_read_sel. It is a combinational per-port selector covering address decode, zero-reg handling and bypass, and is instantiated NUM_RD_PORTS times in a generate loop.

Test Plan:
- Reset then read: write 0xDEADBEEF to r5, then reset and read r5 on port 0. Expect resp_data[31:0]=0 with resp_valid 1 cycle after accept.
- Write then read: write r14=0x12345678, then accept on the next cycle with port0=r14, port1=r0. Expect 0x12345678 and 0. Also write r0=0xFFFFFFFF and check that r0 still reads 0.
- Same-cycle write and read of r7 (old value 0x11, new value 0x22):
  - with PE_RF_WR_BYPASS_EN, port0 returns 0x22;
  - without it, port0 returns 0x11;
  - a follow-up read returns 0x22 in both builds.
- Backpressure:
  - Hold resp_ready=0 for 3 cycles after an accept. Expect req_ready=0, busy=1 and resp_data stable even when r3 is overwritten.
  - Raise resp_ready together with a new req_valid. Expect the new data on the next cycle and resp_valid to stay 1.
- Port mask: req_port_en=2'b10 with addresses r1/r2 (values 0xA, 0xB). Expect port0=0, port1=0xB, resp_port_en=2'b10.
- Reset mid-hold: assert rst while resp_valid=1 and resp_ready=0. Expect resp_valid=0 and req_ready=1 on the following cycle.

Source files
------------

// File: rtl/pe_rf_pkg.sv
// Shared constants and types for the PE register file with handshaked read ports.
package pe_rf_pkg;

  localparam int RF_NUM_REGS     = 32;
  localparam int RF_DATA_W       = 32;
  localparam int RF_NUM_RD_PORTS = 2;

  // Occupancy of the one-entry response buffer.
  typedef enum logic {
    RF_EMPTY = 1'b0,
    RF_FULL  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/pe_rf_read_sel.sv
// Combinational selector for one read port: address decode, zero-register
// handling, same-cycle write forwarding, and masking of disabled ports.
module pe_rf_read_sel
  import pe_rf_pkg::*;
#(
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int DATA_W    = RF_DATA_W,
  parameter int ZERO_REG0 = 1,
  parameter int AW        = $clog2(RF_NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] mem_flat,
  input  logic [AW-1:0]              rd_addr,
  input  logic                       rd_en,
  input  logic                       byp_en,
  input  logic [AW-1:0]              byp_addr,
  input  logic [DATA_W-1:0]          byp_data,
  output logic [DATA_W-1:0]          rd_data
);

  // Zero rule wins over forwarding, forwarding wins over stored contents;
  // disabled ports return a clean zero rather than whatever the address holds.
  always_comb begin
    rd_data = '0;
    if (!rd_en) begin
      rd_data = '0;
    end else if ((ZERO_REG0 != 0) && (rd_addr == '0)) begin
      rd_data = '0;
    end else if (byp_en && (byp_addr == rd_addr)) begin
      rd_data = byp_data;
    end else begin
      rd_data = mem_flat[int'(rd_addr)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/pe_regfile_rdport.sv
// Register file with one write port and NUM_RD_PORTS handshaked read ports.
// Read data is captured into a one-entry output buffer and held until taken.
// Optional macro PE_RF_WR_BYPASS_EN: when defined, a write in the accept cycle
// is forwarded into the captured data (write-first); otherwise read-first.
module pe_regfile_rdport
  import pe_rf_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int DATA_W       = RF_DATA_W,
  parameter int NUM_RD_PORTS = RF_NUM_RD_PORTS,
  parameter int ZERO_REG0    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [NUM_RD_PORTS*$clog2(NUM_REGS)-1:0] req_addr,
  input  logic [NUM_RD_PORTS-1:0]        req_port_en,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [NUM_RD_PORTS*DATA_W-1:0] resp_data,
  output logic [NUM_RD_PORTS-1:0]        resp_port_en,
  output logic                           busy
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS*DATA_W-1:0]     mem_flat;
  logic [NUM_RD_PORTS*DATA_W-1:0] rd_vals;
  rf_state_e                      state;
  rf_state_e                      state_nxt;
  logic                           accept;
  logic                           wr_commit;
  logic                           byp_en;

  assign resp_valid = (state == RF_FULL);
  assign req_ready  = !resp_valid || resp_ready;
  assign accept     = req_valid && req_ready;
  assign busy       = resp_valid && !resp_ready;
  assign wr_commit  = wr_en && !((ZERO_REG0 != 0) && (wr_addr == '0));

`ifdef PE_RF_WR_BYPASS_EN
  assign byp_en = wr_en;
`else
  assign byp_en = 1'b0;
`endif

  // Architectural register storage; writes to r0 are dropped when it is hardwired.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_flat <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_commit && (wr_addr == AW'(i))) begin
          mem_flat[i*DATA_W +: DATA_W] <= wr_data;
        end
      end
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      pe_rf_read_sel #(
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .ZERO_REG0 (ZERO_REG0),
        .AW        (AW)
      ) u_sel (
        .mem_flat (mem_flat),
        .rd_addr  (req_addr[p*AW +: AW]),
        .rd_en    (req_port_en[p]),
        .byp_en   (byp_en),
        .byp_addr (wr_addr),
        .byp_data (wr_data),
        .rd_data  (rd_vals[p*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Buffer occupancy: an accept always fills, a drain without accept empties.
  always_comb begin
    state_nxt = state;
    case (state)
      RF_EMPTY: if (accept) state_nxt = RF_FULL;
      RF_FULL: begin
        if (accept) begin
          state_nxt = RF_FULL;
        end else if (resp_ready) begin
          state_nxt = RF_EMPTY;
        end
      end
      default: state_nxt = RF_EMPTY;
    endcase
  end

  // Response buffer: captured only on accept so held data ignores later writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RF_EMPTY;
      resp_data    <= '0;
      resp_port_en <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        resp_data    <= rd_vals;
        resp_port_en <= req_port_en;
      end
    end
  end

endmodule

// File: tb/tb_pe_regfile_rdport.sv
// Directed self-checking bench for pe_regfile_rdport (default parameters).
module tb_pe_regfile_rdport;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          req_valid;
  logic          req_ready;
  logic [2*AW-1:0] req_addr;
  logic [1:0]    req_port_en;
  logic          resp_valid;
  logic          resp_ready;
  logic [2*DW-1:0] resp_data;
  logic [1:0]    resp_port_en;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  pe_regfile_rdport dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_port_en  (req_port_en),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_port_en (resp_port_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Present one read request for a single cycle.
  task automatic applyStimulus(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
    req_valid = 1'b1; req_addr = {a1, a0}; req_port_en = en;
    tick();
    req_valid = 1'b0;
  endtask

  logic [DW-1:0] exp_r7;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; req_port_en = '0; resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("rst_resp_data", resp_data, 64'd0);
    checkOutput("rst_resp_port_en", {62'd0, resp_port_en}, 64'd0);
    checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Reset clears register contents.
    writeReg(5'd5, 32'hDEADBEEF);
    rst = 1'b1; tick(); rst = 1'b0;
    applyStimulus(5'd5, 5'd0, 2'b01);
    checkOutput("rr_valid", {63'd0, resp_valid}, 64'd1);
    checkOutput("rr_data", resp_data, 64'd0);
    tick();
    checkOutput("rr_drained", {63'd0, resp_valid}, 64'd0);

    // Write then read, with hardwired r0.
    writeReg(5'd14, 32'h12345678);
    applyStimulus(5'd14, 5'd0, 2'b11);
    checkOutput("wr_rd_data", resp_data, {32'h0, 32'h12345678});
    writeReg(5'd0, 32'hFFFFFFFF);
    applyStimulus(5'd0, 5'd14, 2'b11);
    checkOutput("r0_zero", resp_data, {32'h12345678, 32'h0});
    tick();

    // Same-cycle write and read of r7.
    writeReg(5'd7, 32'h11);
`ifdef PE_RF_WR_BYPASS_EN
    exp_r7 = 32'h22;
`else
    exp_r7 = 32'h11;
`endif
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22;
    applyStimulus(5'd7, 5'd0, 2'b01);
    wr_en = 1'b0;
    checkOutput("same_cycle_r7", resp_data, {32'h0, exp_r7});
    applyStimulus(5'd7, 5'd7, 2'b11);
    checkOutput("followup_r7_both", resp_data, {32'h22, 32'h22});
    tick();

    // Backpressure: held data survives overwrite and ignored requests.
    writeReg(5'd3, 32'hAAAA);
    resp_ready = 1'b0;
    applyStimulus(5'd3, 5'd0, 2'b01);
    checkOutput("bp_req_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("bp_busy", {63'd0, busy}, 64'd1);
    req_valid = 1'b1; req_addr = {5'd0, 5'd14}; req_port_en = 2'b01;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hBBBB;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("bp_hold_data", resp_data, {32'h0, 32'hAAAA});
      checkOutput("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
      tick();
    end
    checkOutput("bp_hold_last", resp_data, {32'h0, 32'hAAAA});
    req_addr = {5'd0, 5'd3}; resp_ready = 1'b1;
    #1;
    checkOutput("bp_ready_comb", {63'd0, req_ready}, 64'd1);
    checkOutput("bp_busy_off", {63'd0, busy}, 64'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("bp_new_valid", {63'd0, resp_valid}, 64'd1);
    checkOutput("bp_new_data", resp_data, {32'h0, 32'hBBBB});
    tick();
    checkOutput("bp_drain", {63'd0, resp_valid}, 64'd0);

    // Port mask.
    writeReg(5'd1, 32'hA);
    writeReg(5'd2, 32'hB);
    applyStimulus(5'd1, 5'd2, 2'b10);
    checkOutput("mask_data", resp_data, {32'hB, 32'h0});
    checkOutput("mask_port_en", {62'd0, resp_port_en}, 64'd2);
    tick();

    // Reset during a held response.
    resp_ready = 1'b0;
    applyStimulus(5'd14, 5'd0, 2'b01);
    checkOutput("mid_valid_before", {63'd0, resp_valid}, 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("mid_rst_data", resp_data, 64'd0);
    resp_ready = 1'b1;
    applyStimulus(5'd14, 5'd1, 2'b11);
    checkOutput("mid_rst_mem", resp_data, 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
